// File: rtl/alu_uart_if.sv
// -----------------------------------------------------------------------------
// alu_uart_if
//
// Glue between a UART byte receiver/transmitter pair and a combinational ALU.
// Three received bytes form one frame: operand A, operand B, opcode. The
// operands and opcode are held in registers that drive the ALU. The ALU result
// is then handed to the transmitter with a single start pulse, and the block
// waits for the transmitter to finish before it accepts the next frame.
//
// Optional feature (macro ALU_IF_CARRY_TX_EN):
//   When defined, a second byte is sent after the result. Its value is
//   {NB_DATA-1 zeros, carry}, where carry is sampled together with the result.
//   When undefined, only the result byte is sent and the carry states are not
//   built.
//
// Parameters
//   NB_DATA : operand/result/UART byte width
//   NB_OP   : opcode width (low bits of the received opcode byte)
//
// Ports
//   i_clk        : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_rx_data    : received byte, valid while i_rx_done is high
//   i_rx_done    : one-cycle strobe, new received byte
//   o_data_a     : registered operand A to the ALU
//   o_data_b     : registered operand B to the ALU
//   o_op         : registered opcode to the ALU
//   i_alu_result : combinational ALU result
//   i_alu_carry  : combinational ALU carry
//   o_tx_data    : registered byte to the transmitter
//   o_tx_start   : one-cycle transmit start pulse
//   i_tx_done    : one-cycle strobe, transmitter finished the current byte
//   o_busy       : high while a byte is being sent or awaited
// -----------------------------------------------------------------------------
module alu_uart_if #(
   parameter int NB_DATA = 8,
   parameter int NB_OP   = 6
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_op,
   input  logic [NB_DATA-1:0] i_alu_result,
   input  logic               i_alu_carry,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_busy
);

   typedef enum logic [2:0] {
      GET_A    = 3'd0,
      GET_B    = 3'd1,
      GET_OP   = 3'd2,
      SEND_RES = 3'd3,
      WAIT_RES = 3'd4
`ifdef ALU_IF_CARRY_TX_EN
      ,
      SEND_CRY = 3'd5,
      WAIT_CRY = 3'd6
`endif
   } state_t;

   state_t state;
   state_t state_next;

   // Datapath load enables decoded by the FSM.
   logic cap_a;
   logic cap_b;
   logic cap_op;
   logic load_res;
   logic load_cry;

`ifdef ALU_IF_CARRY_TX_EN
   // Carry sampled alongside the result so the second byte reflects the same
   // operation even though it is sent later.
   logic carry_q;
`endif

   // Not every input bit reaches logic in every build (upper opcode bits are
   // discarded, carry is unused without the carry feature); fold them here so
   // they are visibly accounted for.
   logic unused_inputs;
   assign unused_inputs = ^{i_alu_carry, i_rx_data};

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the values from before the edge, independent of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= GET_A;
      end else begin
         state <= state_next;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state and load-enable decode
   // --------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default before the case statement;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      state_next = state;
      cap_a      = 1'b0;
      cap_b      = 1'b0;
      cap_op     = 1'b0;
      load_res   = 1'b0;
      load_cry   = 1'b0;

      // i_rx_done is only looked at in the GET_* states, so bytes arriving
      // while busy are dropped; i_tx_done is only looked at in WAIT_* states.
      unique case (state)
         GET_A: begin
            if (i_rx_done) begin
               cap_a      = 1'b1;
               state_next = GET_B;
            end
         end
         GET_B: begin
            if (i_rx_done) begin
               cap_b      = 1'b1;
               state_next = GET_OP;
            end
         end
         GET_OP: begin
            if (i_rx_done) begin
               cap_op     = 1'b1;
               state_next = SEND_RES;
            end
         end
         SEND_RES: begin
            load_res   = 1'b1;
            state_next = WAIT_RES;
         end
         WAIT_RES: begin
            if (i_tx_done) begin
`ifdef ALU_IF_CARRY_TX_EN
               state_next = SEND_CRY;
`else
               state_next = GET_A;
`endif
            end
         end
`ifdef ALU_IF_CARRY_TX_EN
         SEND_CRY: begin
            load_cry   = 1'b1;
            state_next = WAIT_CRY;
         end
         WAIT_CRY: begin
            if (i_tx_done) begin
               state_next = GET_A;
            end
         end
`endif
         default: begin
            state_next = GET_A;
         end
      endcase
   end

   // Busy covers every send/wait state; decoded straight from the state flops
   // so it drops together with the asynchronous reset.
   always_comb begin
      o_busy = 1'b0;
      if (state != GET_A && state != GET_B && state != GET_OP) begin
         o_busy = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Operand, opcode and transmit registers
   // --------------------------------------------------------------------------
   // NOTE: all output registers are reset; these are a few control/data flops,
   // not a memory array, and a known zero after reset is observable behaviour.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_data_a   <= '0;
         o_data_b   <= '0;
         o_op       <= '0;
         o_tx_data  <= '0;
         o_tx_start <= 1'b0;
      end else begin
         if (cap_a) begin
            o_data_a <= i_rx_data;
         end
         if (cap_b) begin
            o_data_b <= i_rx_data;
         end
         if (cap_op) begin
            o_op <= i_rx_data[NB_OP-1:0];
         end

         // The start pulse is high only in the cycle after a SEND_* state.
         o_tx_start <= load_res | load_cry;

         if (load_res) begin
            o_tx_data <= i_alu_result;
         end else if (load_cry) begin
`ifdef ALU_IF_CARRY_TX_EN
            o_tx_data <= {{(NB_DATA-1){1'b0}}, carry_q};
`else
            o_tx_data <= '0;
`endif
         end
      end
   end

`ifdef ALU_IF_CARRY_TX_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         carry_q <= 1'b0;
      end else if (load_res) begin
         carry_q <= i_alu_carry;
      end
   end
`endif

endmodule

// File: tb/tb_alu_uart_if.sv
// -----------------------------------------------------------------------------
// tb_alu_uart_if
//
// Directed bench for alu_uart_if. A small behavioural ALU is attached to the
// operand/opcode outputs. Frames are fed as rx strobes, and the transmit side
// is checked cycle by cycle against hand-computed values. Outputs are sampled
// on the falling clock edge; inputs change on the falling edge as well.
// -----------------------------------------------------------------------------
module tb_alu_uart_if;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;

   logic               clk;
   logic               rst_n;
   logic [NB_DATA-1:0] rx_data;
   logic               rx_done;
   logic [NB_DATA-1:0] data_a;
   logic [NB_DATA-1:0] data_b;
   logic [NB_OP-1:0]   op;
   logic [NB_DATA-1:0] alu_result;
   logic               alu_carry;
   logic [NB_DATA-1:0] tx_data;
   logic               tx_start;
   logic               tx_done;
   logic               busy;

   int n_checks = 0;
   int n_pass   = 0;

   alu_uart_if #(
      .NB_DATA (NB_DATA),
      .NB_OP   (NB_OP)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_rx_data    (rx_data),
      .i_rx_done    (rx_done),
      .o_data_a     (data_a),
      .o_data_b     (data_b),
      .o_op         (op),
      .i_alu_result (alu_result),
      .i_alu_carry  (alu_carry),
      .o_tx_data    (tx_data),
      .o_tx_start   (tx_start),
      .i_tx_done    (tx_done),
      .o_busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: MIPS-style function codes, carry = carry-out / borrow.
   always_comb begin
      alu_result = '0;
      alu_carry  = 1'b0;
      case (op)
         6'h20: {alu_carry, alu_result} = {1'b0, data_a} + {1'b0, data_b};
         6'h22: {alu_carry, alu_result} = {1'b0, data_a} - {1'b0, data_b};
         6'h24: alu_result = data_a & data_b;
         6'h25: alu_result = data_a | data_b;
         6'h26: alu_result = data_a ^ data_b;
         6'h27: alu_result = ~(data_a | data_b);
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present one byte for one cycle, starting and ending on a falling edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
   endtask

   task automatic pulse_tx_done();
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
   endtask

   // One complete frame. When collide is set, the final tx_done coincides with
   // an rx strobe of 0xAA that must be dropped.
   task automatic run_frame(input string tag, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] opb,
                            input logic [5:0] exp_op, input logic [7:0] exp_res,
                            input logic exp_cry, input bit collide);
      send_byte(a);
      check({tag, " data_a"}, 32'(data_a), 32'(a));
      check({tag, " busy in GET_B"}, 32'(busy), 32'd0);
      send_byte(b);
      check({tag, " data_b"}, 32'(data_b), 32'(b));
      send_byte(opb);
      // Now in SEND_RES: first cycle after the opcode-capture edge.
      check({tag, " op"}, 32'(op), 32'(exp_op));
      check({tag, " busy in SEND_RES"}, 32'(busy), 32'd1);
      check({tag, " start not early"}, 32'(tx_start), 32'd0);
      @(negedge clk);
      // Second cycle after the capture edge: the start pulse.
      check({tag, " start pulse"}, 32'(tx_start), 32'd1);
      check({tag, " tx_data result"}, 32'(tx_data), 32'(exp_res));
      // A byte arriving while busy must be dropped.
      send_byte(8'h77);
      check({tag, " start single"}, 32'(tx_start), 32'd0);
      check({tag, " data_a held"}, 32'(data_a), 32'(a));
      check({tag, " busy in WAIT"}, 32'(busy), 32'd1);
      check({tag, " tx_data held"}, 32'(tx_data), 32'(exp_res));
`ifdef ALU_IF_CARRY_TX_EN
      pulse_tx_done();
      check({tag, " busy in SEND_CRY"}, 32'(busy), 32'd1);
      check({tag, " start not early cry"}, 32'(tx_start), 32'd0);
      @(negedge clk);
      check({tag, " start pulse cry"}, 32'(tx_start), 32'd1);
      check({tag, " tx_data carry"}, 32'(tx_data), {31'd0, exp_cry});
`else
      // Carry is not transmitted in this build.
      if (exp_cry === 1'bx) begin
         $display("note: %s carry unknown", tag);
      end
`endif
      rx_data = 8'hAA;
      rx_done = collide;
      tx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0;
      tx_done = 1'b0;
      check({tag, " back to GET_A"}, 32'(busy), 32'd0);
      check({tag, " data_a after done"}, 32'(data_a), 32'(a));
      check({tag, " start low after done"}, 32'(tx_start), 32'd0);
   endtask

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n   = 1'b0;
      rx_data = '0;
      rx_done = 1'b0;
      tx_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset data_a", 32'(data_a), 32'd0);
      check("reset data_b", 32'(data_b), 32'd0);
      check("reset op", 32'(op), 32'd0);
      check("reset tx_data", 32'(tx_data), 32'd0);
      check("reset tx_start", 32'(tx_start), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // tx_done outside WAIT_* is ignored.
      pulse_tx_done();
      check("stray tx_done busy", 32'(busy), 32'd0);
      check("stray tx_done start", 32'(tx_start), 32'd0);

      // ADD 5+3 = 8, no carry.
      run_frame("add", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 1'b0, 1'b0);
      // SUB 3-5 = 0xFE, borrow.
      run_frame("sub", 8'h03, 8'h05, 8'h22, 6'h22, 8'hFE, 1'b1, 1'b0);
      // Opcode upper bits discarded: 0xE5 -> 0x25 (OR).
      run_frame("or", 8'hF0, 8'h0F, 8'hE5, 6'h25, 8'hFF, 1'b0, 1'b1);
      // Next frame right after the colliding rx/tx strobes: AND.
      run_frame("and", 8'h01, 8'h01, 8'h24, 6'h24, 8'h01, 1'b0, 1'b0);

      // Reset after operand B: outputs clear immediately (asynchronously).
      send_byte(8'h11);
      send_byte(8'h22);
      check("pre-reset data_b", 32'(data_b), 32'h22);
      #1 rst_n = 1'b0;
      #1;
      check("async reset data_a", 32'(data_a), 32'd0);
      check("async reset data_b", 32'(data_b), 32'd0);
      check("async reset op", 32'(op), 32'd0);
      check("async reset tx_data", 32'(tx_data), 32'd0);
      check("async reset busy", 32'(busy), 32'd0);
      // Strobes during reset are not acted on.
      @(negedge clk);
      send_byte(8'h55);
      check("rx during reset", 32'(data_a), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run_frame("post-reset add", 8'h02, 8'h02, 8'h20, 6'h20, 8'h04, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_uart_if.md
ALU_UART_IF -- requirements
Module: alu_uart_if

Interface
REQ-001 Parameter NB_DATA, default 8, operand/result/UART byte width.
REQ-002 Parameter NB_OP, default 6, opcode width, taken from the low bits of the received opcode byte.
REQ-003 i_clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_rx_data  in  NB_DATA  byte from UART receiver, valid when i_rx_done=1.
REQ-006 i_rx_done  in  1  one-cycle strobe, new received byte.
REQ-007 o_data_a  out  NB_DATA  registered operand A to ALU.
REQ-008 o_data_b  out  NB_DATA  registered operand B to ALU.
REQ-009 o_op  out  NB_OP  registered opcode to ALU.
REQ-010 i_alu_result  in  NB_DATA  combinational ALU result.
REQ-011 i_alu_carry  in  1  combinational ALU carry.
REQ-012 o_tx_data  out  NB_DATA  registered byte to UART transmitter.
REQ-013 o_tx_start  out  1  one-cycle start pulse to transmitter.
REQ-014 i_tx_done  in  1  one-cycle strobe, transmitter finished current byte.
REQ-015 o_busy  out  1  high while in any send/wait state.

Function
REQ-016 FSM states: GET_A, GET_B, GET_OP, SEND_RES, WAIT_RES; plus SEND_CRY, WAIT_CRY when ALU_IF_CARRY_TX_EN defined.
REQ-017 GET_A: on i_rx_done, o_data_a <= i_rx_data, go GET_B; otherwise hold.
REQ-018 GET_B: on i_rx_done, o_data_b <= i_rx_data, go GET_OP.
REQ-019 GET_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0] (upper bits discarded), go SEND_RES.
REQ-020 SEND_RES (one cycle): o_tx_data <= i_alu_result, o_tx_start <= 1, go WAIT_RES; pulse visible exactly one cycle, i.e. the second cycle after the opcode-capture edge.
REQ-021 o_tx_start SHALL be 0 in every cycle other than the one following a SEND_* state.
REQ-022 WAIT_RES: on i_tx_done go GET_A (macro undefined) or SEND_CRY (macro defined); otherwise hold.
REQ-023 i_rx_done while o_busy=1 SHALL be ignored; byte dropped, operand/op registers unchanged.
REQ-024 i_rx_done and i_tx_done in the same WAIT_* cycle: tx_done acted on, rx byte dropped.
REQ-025 i_tx_done outside WAIT_* states SHALL be ignored.
REQ-026 o_data_a, o_data_b, o_op SHALL hold their values until overwritten by the next capture, so ALU output stays stable during transmission.
REQ-027 Back-to-back operations: after return to GET_A, next frame handled identically, no idle cycles required.

Reset
REQ-028 i_rst_n=0 SHALL asynchronously force state GET_A and all outputs to 0 (o_data_a, o_data_b, o_op, o_tx_data, o_tx_start, o_busy).
REQ-029 Reset mid-frame or mid-transmit SHALL discard partial operands; first byte after release is operand A.
REQ-030 Reset release SHALL take effect on the next rising i_clk; no strobes acted on while i_rst_n=0.

Configuration
REQ-031 Macro ALU_IF_CARRY_TX_EN: when defined, SEND_CRY latches o_tx_data <= {NB_DATA-1 zeros, carry captured in SEND_RES}, pulses o_tx_start, WAIT_CRY returns to GET_A on i_tx_done; when undefined, only the result byte is sent and carry states do not exist.

Verification
REQ-032 rx 0x05, 0x03, 0x20 (ADD), ALU model attached -> o_tx_data=0x08, single o_tx_start pulse two cycles after op strobe; with macro second byte 0x00.
REQ-033 rx 0x03, 0x05, 0x22 (SUB) -> o_tx_data=0xFE; with macro second byte 0x01.
REQ-034 rx 0xF0, 0x0F, 0xE5 -> o_op=0x25 (OR), o_tx_data=0xFF.
REQ-035 rx strobes 0xAA during WAIT_RES, simultaneous with i_tx_done -> o_data_a unchanged, state GET_A, next frame 0x01,0x01,0x24 -> 0x01.
REQ-036 assert i_rst_n=0 after operand B received -> all outputs 0 immediately; then 0x02,0x02,0x20 -> 0x04.
